// File: rtl/isa_pkg.sv
// isa_pkg -- shared LEGv8 field layout constants and format enum.
//
// Used by the instruction encoder and its immediate range checker.
//   I-type: [31:22] opcode, [21:10] imm12, [9:5] rn, [4:0] rd
//   D-type: [31:21] opcode, [20:12] imm9, [11:10] op2=00, [9:5] rn, [4:0] rt
package isa_pkg;

    localparam int I_IMM_LSB = 10;
    localparam int I_IMM_W   = 12;
    localparam int D_IMM_LSB = 12;
    localparam int D_IMM_W   = 9;
    localparam int OPC_I_W   = 10;
    localparam int OPC_D_W   = 11;
    localparam int REG_W     = 5;
    localparam int RN_LSB    = 5;
    localparam int RD_LSB    = 0;

    // Width of the dropped-input counter and its saturation value.
    localparam int              ERR_W   = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic {
        FMT_I = 1'b0,
        FMT_D = 1'b1
    } fmt_e;

endpackage

// File: rtl/imm_range_check.sv
// imm_range_check -- combinational check that a 64-bit immediate survives
// truncation to its instruction field and sign-extension back.
//
// Ports:
//   imm       in  64 : two's-complement immediate
//   is_d_type in  1  : 1 = 9-bit D-type field, 0 = 12-bit I-type field
//   in_range  out 1  : immediate fits the selected field
module imm_range_check
    import isa_pkg::*;
(
    input  logic [63:0] imm,
    input  logic        is_d_type,
    output logic        in_range
);

    // A value fits an N-bit signed field when bits [63:N-1] are all equal,
    // i.e. all of them are copies of the field's sign bit.
    logic [63-(I_IMM_W-1):0] i_hi;
    logic [63-(D_IMM_W-1):0] d_hi;

    always_comb begin
        i_hi = imm[63:I_IMM_W-1];
        d_hi = imm[63:D_IMM_W-1];
        if (is_d_type) begin
            in_range = (&d_hi) || ~(|d_hi);
        end else begin
            in_range = (&i_hi) || ~(|i_hi);
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder -- streaming LEGv8 instruction encoder.
//
// Packs decoded fields into 32-bit I-type or D-type words, tags each word
// with a sequential instruction-memory word address and buffers it in a
// 2-entry FIFO in front of the memory write port.
//
// Build option: ENC_RANGE_CHECK_EN
//   defined   : out-of-range immediates are accepted but dropped, and
//               counted in err_sticky / err_count (saturating at 255).
//   undefined : immediates are truncated to their field and always written;
//               err_sticky / err_count are tied to 0 and err_clr is ignored.
//
// Ports:
//   clk, reset                : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready       : input handshake; in_ready depends on
//                               registered occupancy only
//   in_is_d_type, in_opcode,
//   in_rn, in_rd, in_imm      : decoded fields (in_rd is Rt for D-type)
//   addr_load, addr_base      : reload the word-address counter
//   out_valid / out_ready     : output handshake
//   out_instr, out_addr       : head-of-FIFO word and its address
//   err_clr, err_sticky,
//   err_count                 : dropped-input status
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds its payload stable while valid && !ready.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_d_type,
    input  logic [10:0]       in_opcode,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rd,
    input  logic [63:0]       in_imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_base,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              err_clr,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_count
);

    localparam int unsigned DEPTH = 2;

    logic [31:0]       buf_instr [DEPTH];
    logic [ADDR_W-1:0] buf_addr  [DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [ADDR_W-1:0] addr_cnt;

    fmt_e              fmt;
    logic [31:0]       word;
    logic              accept;
    logic              in_range;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic [ADDR_W-1:0] addr_cnt_next;

`ifdef ENC_RANGE_CHECK_EN
    imm_range_check u_range (
        .imm       (in_imm),
        .is_d_type (in_is_d_type),
        .in_range  (in_range)
    );
`else
    assign in_range = 1'b1;
    // Only the low field bits of the immediate matter when nothing is checked.
    logic unused_inputs;
    assign unused_inputs = ^{in_imm[63:I_IMM_W], err_clr};
`endif

    // Occupancy-only ready: a full buffer refuses input even when it is
    // being popped in the same cycle.
    assign in_ready  = (count < 2'(DEPTH));
    assign out_valid = (count != 2'd0);
    assign out_instr = buf_instr[rd_ptr];
    assign out_addr  = buf_addr[rd_ptr];

    always_comb begin
        fmt  = in_is_d_type ? FMT_D : FMT_I;
        word = '0;
        word[RN_LSB +: REG_W] = in_rn;
        word[RD_LSB +: REG_W] = in_rd;
        case (fmt)
            FMT_D: begin
                word[31 -: OPC_D_W]         = in_opcode[OPC_D_W-1:0];
                word[D_IMM_LSB +: D_IMM_W]  = in_imm[D_IMM_W-1:0];
            end
            default: begin
                word[31 -: OPC_I_W]         = in_opcode[OPC_I_W-1:0];
                word[I_IMM_LSB +: I_IMM_W]  = in_imm[I_IMM_W-1:0];
            end
        endcase
    end

    always_comb begin
        accept    = in_valid && in_ready;
        push      = accept && in_range;
        pop       = out_valid && out_ready;
        // A load in the same cycle as a push gives that word the base address.
        push_addr = addr_load ? addr_base : addr_cnt;
        if (push) begin
            addr_cnt_next = push_addr + ADDR_W'(1);
        end else if (addr_load) begin
            addr_cnt_next = addr_base;
        end else begin
            addr_cnt_next = addr_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            addr_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_addr[i]  <= '0;
            end
        end else begin
            if (push) begin
                buf_instr[wr_ptr] <= word;
                buf_addr[wr_ptr]  <= push_addr;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            addr_cnt <= addr_cnt_next;
        end
    end

`ifdef ENC_RANGE_CHECK_EN
    logic drop;
    assign drop = accept && !in_range;

    // A drop coinciding with err_clr restarts the count at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (drop) begin
            err_sticky <= 1'b1;
            if (err_clr) begin
                err_count <= ERR_W'(1);
            end else if (err_count != ERR_MAX) begin
                err_count <= err_count + ERR_W'(1);
            end
        end else if (err_clr) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end
    end
`else
    assign err_sticky = 1'b0;
    assign err_count  = '0;
`endif

endmodule
